conway_memory_sequencer: RTL

- Sequences one system memory instance through clear, serial load and run phases.
- Drives the memory's LOAD_MODE, RUN_MODE, serial input and reset.
- Accepts a serial seed pattern over a valid/ready handshake, then issues a programmed number of generation-update cycles.
- Sits between the top-level control/host interface and the cell memory.

---
 rtl/conway_memory_sequencer_if.sv | 30 +++
 rtl/conway_memory_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/conway_memory_sequencer_if.sv
// Host/control and cell-memory signals of the Conway memory sequencer.
// The slave modport is the sequencer; the master modport is the host plus memory side.
interface conway_memory_sequencer_if #(
  parameter int GEN_WIDTH = 8
);
  logic                 LOAD_REQ;
  logic                 RUN_REQ;
  logic                 ABORT;
  logic [GEN_WIDTH-1:0] NUM_GENS;
  logic                 SERIAL_DATA;
  logic                 SERIAL_VALID;
  logic                 SERIAL_READY;
  logic                 MEM_RESET;
  logic                 MEM_SERIAL;
  logic                 LOAD_MODE;
  logic                 RUN_MODE;
  logic                 BUSY;
  logic                 DONE;
  logic [GEN_WIDTH-1:0] GEN_COUNT;

  modport slave (
    input  LOAD_REQ, RUN_REQ, ABORT, NUM_GENS, SERIAL_DATA, SERIAL_VALID,
    output SERIAL_READY, MEM_RESET, MEM_SERIAL, LOAD_MODE, RUN_MODE, BUSY, DONE, GEN_COUNT
  );

  modport master (
    output LOAD_REQ, RUN_REQ, ABORT, NUM_GENS, SERIAL_DATA, SERIAL_VALID,
    input  SERIAL_READY, MEM_RESET, MEM_SERIAL, LOAD_MODE, RUN_MODE, BUSY, DONE, GEN_COUNT
  );
endinterface

// File: rtl/conway_memory_sequencer.sv
// Sequences one cell memory through clear, serial seed load and generation run phases.
// CONWAY_PRESCALE_EN: RUN_MODE becomes a one-cycle pulse every PRESCALE clocks.
module conway_memory_sequencer #(
  parameter int DATA_SIZE = 5,
  parameter int GEN_WIDTH = 8,
  parameter int PRESCALE  = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  conway_memory_sequencer_if.slave   bus
);

  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
`ifdef CONWAY_PRESCALE_EN
  localparam int STEP = PRESCALE;
`else
  localparam int STEP = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_LOADED,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 mem_reset_q, mem_reset_d;
  logic                 mem_serial_q, mem_serial_d;
  logic                 load_mode_q, load_mode_d;
  logic                 run_mode_q, run_mode_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d;
  logic [GEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 accept;

  assign accept = bus.SERIAL_VALID && (state_q == S_LOAD);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      mem_reset_q  <= 1'b0;
      mem_serial_q <= 1'b0;
      load_mode_q  <= 1'b0;
      run_mode_q   <= 1'b0;
      bit_cnt_q    <= '0;
      gen_count_q  <= '0;
      remaining_q  <= '0;
      presc_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_reset_q  <= mem_reset_d;
      mem_serial_q <= mem_serial_d;
      load_mode_q  <= load_mode_d;
      run_mode_q   <= run_mode_d;
      bit_cnt_q    <= bit_cnt_d;
      gen_count_q  <= gen_count_d;
      remaining_q  <= remaining_d;
      presc_q      <= presc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_reset_d  = 1'b0;
    mem_serial_d = mem_serial_q;
    load_mode_d  = 1'b0;
    run_mode_d   = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    gen_count_d  = gen_count_q;
    remaining_d  = remaining_q;
    presc_d      = presc_q;

    case (state_q)
      S_IDLE, S_LOADED, S_DONE: begin
        // A load request outranks a run request arriving in the same cycle.
        if (bus.LOAD_REQ) begin
          state_d     = S_CLEAR;
          mem_reset_d = 1'b1;
        end else if (bus.RUN_REQ) begin
          gen_count_d = '0;
          remaining_d = bus.NUM_GENS;
          presc_d     = '0;
          if (bus.NUM_GENS == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_RUN;
            run_mode_d = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        bit_cnt_d = '0;
        state_d   = bus.ABORT ? S_IDLE : S_LOAD;
      end

      S_LOAD: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (accept) begin
          mem_serial_d = bus.SERIAL_DATA;
          load_mode_d  = 1'b1;
          bit_cnt_d    = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_SIZE - 1)) begin
            state_d = S_LOADED;
          end
        end
      end

      S_RUN: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (run_mode_q) begin
          gen_count_d = gen_count_q + GEN_WIDTH'(1);
          remaining_d = remaining_q - GEN_WIDTH'(1);
          if (remaining_q == GEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end else if (STEP == 1) begin
            run_mode_d = 1'b1;
          end else begin
            presc_d = PW'(1);
          end
        end else if (presc_q == PW'(STEP - 1)) begin
          // Gap between pulses has elapsed; next cycle carries the generation pulse.
          run_mode_d = 1'b1;
          presc_d    = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.SERIAL_READY = (state_q == S_LOAD);
  assign bus.BUSY         = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.DONE         = (state_q == S_DONE);
  assign bus.MEM_RESET    = mem_reset_q;
  assign bus.MEM_SERIAL   = mem_serial_q;
  assign bus.LOAD_MODE    = load_mode_q;
  assign bus.RUN_MODE     = run_mode_q;
  assign bus.GEN_COUNT    = gen_count_q;

endmodule
